rand_gen: RTL
=============

RAND_GEN -- requirements
Module: rand_gen

Interface
REQ-001 Parameter WIDTH, default 32: LFSR state width per channel, minimum 8.
REQ-002 Parameter TAPS, default 32'h80200003: feedback tap mask for x^32+x^22+x^2+x+1, WIDTH bits.
REQ-003 Parameter CHANNELS, default 4: number of independent LFSR channels, 1 to 8.
REQ-004 Parameter OUT_W, default 4: signed sample width per channel, 2 to 8.
REQ-005 Parameter WARMUP, default 16: discarded steps after reset or seed load, minimum 1.
REQ-006 clock  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  when low, freezes all state, including FSM, counter, LFSRs and outputs.
REQ-009 seed_load  input  1  loads seed_data into all channels; ignores enable.
REQ-010 seed_data  input  WIDTH  seed base value.
REQ-011 free_run  input  1  1: step every enabled cycle; 0: step per accepted transfer.
REQ-012 out_ready  input  1  consumer accepts rand_out.
REQ-013 out_valid  output  1  rand_out holds a valid sample.
REQ-014 rand_out  output  CHANNELS*OUT_W  channel c occupies bits [c*OUT_W +: OUT_W].
REQ-015 busy  output  1  high while in WARMUP.

Function
REQ-016 Each step shall compute fb = XOR-reduce(state & TAPS) and set next = {state[WIDTH-2:0], fb}.
REQ-017 Seed derivation shall be: base = (seed_data==0) ? DEFAULT_SEED : seed_data; channel c seed = rotate-left(base, 8*c mod WIDTH) XOR c; a zero result shall be replaced by DEFAULT_SEED.
REQ-018 Sample per channel shall be s = state[OUT_W-1:0]; s equal to 1 followed by zeros (most-negative value) shall be output as 0, keeping the range symmetric.
REQ-019 The FSM shall have two states: WARMUP and RUN.
REQ-020 In WARMUP, each enabled edge shall step all channels and decrement the counter, loaded with WARMUP on entry.
REQ-021 On the edge that performs the last warm-up step, the FSM shall enter RUN and register samples of the post-step state into rand_out, and out_valid shall rise.
REQ-022 In RUN with free_run=1, each enabled edge shall step and re-register rand_out; out_valid shall stay 1; out_ready is ignored.
REQ-023 In RUN with free_run=0, a step and rand_out update shall occur only on an enabled edge with out_valid && out_ready; otherwise rand_out shall hold stable.
REQ-024 seed_load shall have priority over everything: next edge loads the channel seeds, reloads the counter, enters WARMUP and clears out_valid, in any state and regardless of enable.
REQ-025 A change of free_run mid-RUN shall take effect on the next edge without losing or duplicating a sample.
REQ-026 LFSR state shall never become zero.

Reset
REQ-027 Reset shall load the channel seeds derived from DEFAULT_SEED = 32'h8EAF696C (truncated or zero-extended to WIDTH), set the counter to WARMUP and the FSM to WARMUP.
REQ-028 Reset values shall be out_valid=0, rand_out=0 and busy=1.
REQ-029 Reset asserted mid-operation shall override seed_load and enable immediately.

Structure
REQ-030 Package rand_pkg shall hold DEFAULT_SEED, DEFAULT_TAPS and the FSM state typedef.
REQ-031 Sub-module lfsr_channel (one state register with load/step and sample/limit output) shall be instantiated CHANNELS times.
REQ-032 Top-level rand_gen shall own the FSM, warm-up counter, handshake and seed derivation.

Verification (bench: CHANNELS=1, OUT_W=4, default WIDTH/TAPS)
REQ-033 WARMUP=2, load seed 0x00000001, enable=1 -> state 0x3, then 0x6; out_valid high after 2nd edge, rand_out=4'h6, busy=0.
REQ-034 Continue, free_run=0, out_ready pulsed once -> state 0xD, rand_out=4'hD; out_ready held low 5 cycles -> rand_out stays 4'hD.
REQ-035 WARMUP=1, load seed 0x00000004 -> state 0x8, sample 4'b1000 limited, rand_out=4'h0, out_valid=1.
REQ-036 Load seed 0x00000000 -> channel state equals DEFAULT_SEED before warm-up; never zero over 10^5 steps.
REQ-037 seed_load asserted in RUN while out_ready=1 -> out_valid=0 next edge, busy=1, and no extra step taken.
REQ-038 enable=0 for 10 cycles in RUN with free_run=1 -> rand_out and state frozen; reset pulse mid-warm-up -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared constants and FSM state type for the multi-channel LFSR random generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rand_pkg;

    // Seed used after reset and whenever a zero seed would otherwise be loaded.
    localparam logic [31:0] DEFAULT_SEED = 32'h8EAF696C;

    // Feedback taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;

    // ST_WARMUP: stepping and discarding samples; ST_RUN: samples are presented.
    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/lfsr_channel.sv
// One Fibonacci LFSR channel: state register with load/step and a limited signed sample of the post-step state.
// Latency: load/step take effect on the next rising edge; sample_nxt is combinational from the current state.
// Backpressure: none here; the parent decides when to step.
//
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset (state <- RESET_SEED)
//   load, seed     : load seed on the next edge (load wins over step)
//   step           : advance the LFSR one position on the next edge
//   sample_nxt     : OUT_W-bit sample of the value the state takes if stepped now
module lfsr_channel #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   TAPS       = '1,
    parameter int                 OUT_W      = 4,
    parameter logic [WIDTH-1:0]   RESET_SEED = '1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   seed,
    input  logic               step,
    output logic [OUT_W-1:0]   sample_nxt
);

    // 1 followed by zeros: the most negative two's-complement value.
    localparam logic [OUT_W-1:0] MOST_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] stepped;
    logic             fb;

    always_comb begin
        fb      = ^(state_q & TAPS);
        stepped = {state_q[WIDTH-2:0], fb};
        // With the top tap set the shift map is invertible, so zero cannot be
        // reached from a non-zero state. For a tap mask lacking that bit this
        // keeps the channel alive instead of locking up at zero.
        if (stepped == '0) begin
            stepped = RESET_SEED;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (step) begin
            state_d = stepped;
        end
    end

    // Fold the most negative value to zero so the output range is symmetric.
    always_comb begin
        sample_nxt = stepped[OUT_W-1:0];
        if (sample_nxt == MOST_NEG) begin
            sample_nxt = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RESET_SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/rand_gen.sv
// Multi-channel LFSR random sample generator with warm-up, seed reload and valid/ready output.
// Latency: WARMUP enabled edges after reset/seed load until out_valid; then one sample per step.
// Backpressure: free_run=0 steps only on out_valid && out_ready; free_run=1 ignores out_ready.
//
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   enable                : low freezes FSM, counter, LFSRs and outputs (seed_load still acts)
//   seed_load, seed_data  : reseed all channels from seed_data and restart warm-up
//   free_run              : 1 = step every enabled edge, 0 = step per accepted transfer
//   out_ready, out_valid  : output handshake
//   rand_out              : channel c sample at [c*OUT_W +: OUT_W]
//   busy                  : high while warming up
module rand_gen
    import rand_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_TAPS),
    parameter int               CHANNELS = 4,
    parameter int               OUT_W    = 4,
    parameter int               WARMUP   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        seed_load,
    input  logic [WIDTH-1:0]            seed_data,
    input  logic                        free_run,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [CHANNELS*OUT_W-1:0]   rand_out,
    output logic                        busy
);

    localparam logic [WIDTH-1:0] DSEED    = WIDTH'(DEFAULT_SEED);
    localparam int               CNT_W    = $clog2(WARMUP + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    // Per-channel seed: rotate the base left by 8*c, mix in the channel index,
    // and never hand a zero seed to an LFSR.
    function automatic logic [WIDTH-1:0] chan_seed(input logic [WIDTH-1:0] base, input int c);
        int               r;
        logic [WIDTH-1:0] rot;
        logic [WIDTH-1:0] s;
        r = (8 * c) % WIDTH;
        if (r == 0) begin
            rot = base;
        end else begin
            rot = (base << r) | (base >> (WIDTH - r));
        end
        s = rot ^ WIDTH'(c);
        chan_seed = (s == '0) ? DSEED : s;
    endfunction

    fsm_state_t                 fsm_q;
    fsm_state_t                 fsm_d;
    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           cnt_d;
    logic                       out_valid_q;
    logic                       out_valid_d;
    logic [CHANNELS*OUT_W-1:0]  rand_out_q;
    logic [CHANNELS*OUT_W-1:0]  rand_out_d;

    logic                       ch_load;
    logic                       ch_step;
    logic                       capture;
    logic [WIDTH-1:0]           seed_base;
    logic [OUT_W-1:0]           samp_nxt [CHANNELS];

    assign seed_base = (seed_data == '0) ? DSEED : seed_data;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [WIDTH-1:0] ch_seed;

            assign ch_seed = chan_seed(seed_base, c);

            lfsr_channel #(
                .WIDTH      (WIDTH),
                .TAPS       (TAPS),
                .OUT_W      (OUT_W),
                .RESET_SEED (chan_seed(DSEED, c))
            ) u_ch (
                .clock      (clock),
                .reset      (reset),
                .load       (ch_load),
                .seed       (ch_seed),
                .step       (ch_step),
                .sample_nxt (samp_nxt[c])
            );
        end
    endgenerate

    // Next-state logic. seed_load outranks enable; rand_out is only rewritten
    // on an edge that also steps, so it always shows the current LFSR state.
    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        ch_load     = 1'b0;
        ch_step     = 1'b0;
        capture     = 1'b0;

        if (seed_load) begin
            ch_load     = 1'b1;
            cnt_d       = CNT_INIT;
            fsm_d       = ST_WARMUP;
            out_valid_d = 1'b0;
        end else if (enable) begin
            case (fsm_q)
                ST_WARMUP: begin
                    ch_step = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    // The last warm-up step also produces the first sample.
                    if (cnt_q <= CNT_LAST) begin
                        fsm_d       = ST_RUN;
                        out_valid_d = 1'b1;
                        capture     = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (free_run || (out_valid_q && out_ready)) begin
                        ch_step = 1'b1;
                        capture = 1'b1;
                    end
                end
                default: begin
                    fsm_d = ST_WARMUP;
                    cnt_d = CNT_INIT;
                end
            endcase
        end
    end

    always_comb begin
        rand_out_d = rand_out_q;
        if (capture) begin
            for (int c = 0; c < CHANNELS; c++) begin
                rand_out_d[c*OUT_W +: OUT_W] = samp_nxt[c];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q       <= ST_WARMUP;
            cnt_q       <= CNT_INIT;
            out_valid_q <= 1'b0;
            rand_out_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            rand_out_q  <= rand_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rand_out  = rand_out_q;
    assign busy      = (fsm_q == ST_WARMUP);

endmodule
